// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and field positions for the fetch stage and its next-PC helper.
// The opcode field bounds are used by the fetch unit to drive the control unit.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  // Word-aligned, sign-extended branch displacement taken from the low halfword.
  function automatic logic [31:0] branch_disp(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Purely combinational next-PC selection: sequential, conditional branch or jump.
// A jump overrides a taken branch when the control unit asserts both.
module npc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        is_beq_i,
  input  logic        jmp_i,
  input  logic        alu_zero_i,
  output logic [31:0] npc_o,
  output logic [31:0] pc_plus4_o,
  output logic        br_taken_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jt_pc;
  logic        beq_taken;

  // All adds are 32-bit and wrap modulo 2^32, including negative displacements.
  assign seq_pc     = pc_i + 32'd4;
  assign br_pc      = seq_pc + branch_disp(instr_i[15:0]);
  assign jt_pc      = {seq_pc[31:28], instr_i[25:0], 2'b00};
  assign beq_taken  = is_beq_i & alu_zero_i;

  always_comb begin
    npc_o = seq_pc;
    if (jmp_i) begin
      npc_o = jt_pc;
    end else if (beq_taken) begin
      npc_o = br_pc;
    end
  end

  assign pc_plus4_o = seq_pc;
  assign br_taken_o = jmp_i | beq_taken;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// holds the returned word for decode until execute retires it.
//
// Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
// once raised, imem_req_valid and imem_addr stay put until that transfer. The
// response is valid-only: exactly one imem_resp_valid pulse per accepted request,
// never in the acceptance cycle, and only honoured while waiting in S_WAIT.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        is_beq,
  input  logic        jmp,
  input  logic        alu_zero,
  output logic        br_taken,
  output logic [1:0]  fsm_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  npc;
  logic         npc_redirect;

  npc_calc u_npc (
    .pc_i       (pc_q),
    .instr_i    (instr_q),
    .is_beq_i   (is_beq),
    .jmp_i      (jmp),
    .alu_zero_i (alu_zero),
    .npc_o      (npc),
    .pc_plus4_o (pc_plus4),
    .br_taken_o (npc_redirect)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    imem_req_valid = 1'b0;
    unique case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          instr_d       = imem_resp_data;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        // A retire without a held instruction is meaningless and dropped.
        if (retire && instr_valid_q) begin
          pc_d          = npc;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign instr_valid = instr_valid_q;
  assign br_taken    = retire & instr_valid_q & npc_redirect;
  assign fsm_state   = state_q;

  // The PC must stay word aligned from reset onward.
  a_reset_pc_aligned : assert property (@(posedge clk) RESET_PC[1:0] == 2'b00);

  // A response is only meaningful while a request is outstanding.
  a_resp_only_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default-reset instance plus a second
// instance reset to 0x9000_0010 that shares all inputs, for upper-region jumps.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        retire, is_beq, jmp, alu_zero;

  logic        imem_req_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        instr_valid, br_taken;
  logic [1:0]  fsm_state;

  logic        hi_req_valid;
  logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc_plus4;
  logic [5:0]  hi_opcode;
  logic        hi_instr_valid, hi_br_taken;
  logic [1:0]  hi_state;

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retire(retire), .is_beq(is_beq), .jmp(jmp), .alu_zero(alu_zero),
    .br_taken(br_taken), .fsm_state(fsm_state)
  );

  instr_fetch_unit #(.RESET_PC(32'h9000_0010)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(hi_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(hi_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr(hi_instr), .opcode(hi_opcode), .instr_valid(hi_instr_valid), .pc(hi_pc),
    .pc_plus4(hi_pc_plus4),
    .retire(retire), .is_beq(is_beq), .jmp(jmp), .alu_zero(alu_zero),
    .br_taken(hi_br_taken), .fsm_state(hi_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Entered at a negedge with the DUT in S_REQ; leaves at a negedge in S_HOLD.
  task automatic fetch(input logic [31:0] word, input int rdy_dly, input int rsp_dly,
                       input logic early_retire);
    logic [31:0] a;
    a = exp_q.pop_front();
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("imem_addr", imem_addr, a);
    chk("req_state", {30'b0, fsm_state}, 32'(S_REQ));
    for (int i = 0; i < rdy_dly; i++) begin
      retire = early_retire;
      @(negedge clk);
      retire = 1'b0;
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, a);
      chk("stall_state", {30'b0, fsm_state}, 32'(S_REQ));
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_state", {30'b0, fsm_state}, 32'(S_WAIT));
    chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      retire = early_retire;
      @(negedge clk);
      retire = 1'b0;
      chk("wait_hold_state", {30'b0, fsm_state}, 32'(S_WAIT));
      chk("wait_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("wait_req_valid2", {31'b0, imem_req_valid}, 32'd0);
      chk("wait_pc", pc, a);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    chk("hold_state", {30'b0, fsm_state}, 32'(S_HOLD));
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, word);
    chk("opcode", {26'b0, opcode}, {26'b0, word[31:26]});
    chk("hold_pc", pc, a);
    chk("pc_plus4", pc_plus4, a + 32'd4);
  endtask

  // Entered at a negedge in S_HOLD; retires and leaves at the next negedge in S_REQ.
  task automatic do_retire(input logic beq_v, input logic jmp_v, input logic zero_v,
                           input logic exp_br);
    is_beq = beq_v; jmp = jmp_v; alu_zero = zero_v; retire = 1'b1;
    #1;
    chk("br_taken", {31'b0, br_taken}, {31'b0, exp_br});
    @(negedge clk);
    retire = 1'b0; is_beq = 1'b0; jmp = 1'b0; alu_zero = 1'b0;
    chk("post_retire_state", {30'b0, fsm_state}, 32'(S_REQ));
    chk("post_retire_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned t0;
    logic [31:0] seq_words[4];
    seq_words = '{32'h8C01_0000, 32'h0000_0020, 32'hAC02_0004, 32'h2003_0007};
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    retire = 1'b0; is_beq = 1'b0; jmp = 1'b0; alu_zero = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_hi_pc", hi_pc, 32'h9000_0010);

    // Sequential run, three cycles per instruction.
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) chk("seq_cycles", cyc - t0, 32'd3);
      fetch(seq_words[i], 0, 0, 1'b0);
      do_retire(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Jump to 0x40, taken beq back to 0x3C, jump to 0x40, untaken beq to 0x44.
    exp_q.push_back(32'h10); exp_q.push_back(32'h40); exp_q.push_back(32'h3C);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    fetch(32'h0800_0010, 0, 0, 1'b0);
    do_retire(1'b0, 1'b1, 1'b0, 1'b1);
    fetch(32'h1000_FFFE, 0, 0, 1'b0);
    do_retire(1'b1, 1'b0, 1'b1, 1'b1);
    fetch(32'h0800_0010, 0, 0, 1'b0);
    do_retire(1'b0, 1'b1, 1'b0, 1'b1);
    fetch(32'h1000_FFFE, 0, 0, 1'b0);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure with stray retires while nothing is held.
    fetch(32'h2000_0005, 5, 4, 1'b1);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for a response at 0x48.
    exp_q.push_back(32'h48);
    chk("pre_rst_addr", imem_addr, exp_q.pop_front());
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("pre_rst_state", {30'b0, fsm_state}, 32'(S_WAIT));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("wrst_state", {30'b0, fsm_state}, 32'(S_REQ));
    chk("wrst_pc", pc, 32'h0);
    chk("wrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("wrst_instr", instr, 32'h0);
    chk("wrst_hi_pc", hi_pc, 32'h9000_0010);

    // Jump wins over a taken beq; upper PC nibble comes from pc + 4.
    exp_q.push_back(32'h0); exp_q.push_back(32'h400);
    fetch(32'h0800_0100, 0, 0, 1'b0);
    chk("hi_hold_valid", {31'b0, hi_instr_valid}, 32'd1);
    chk("hi_hold_pc", hi_pc, 32'h9000_0010);
    do_retire(1'b1, 1'b1, 1'b1, 1'b1);
    chk("hi_jmp_pc", hi_pc, 32'h9000_0400);
    chk("hi_jmp_addr", hi_addr, 32'h9000_0400);

    // Negative branch wraps below zero, then sequential wrap back to zero.
    exp_q.push_back(32'hFFFF_FFFC);
    fetch(32'h1000_FEFE, 0, 0, 1'b0);
    do_retire(1'b1, 1'b0, 1'b1, 1'b1);
    fetch(32'h0000_0000, 0, 0, 1'b0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h0);
    chk("wrap_pc", pc, exp_q.pop_front());
    chk("wrap_addr", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
